reg_file_write_queue: RTL and testbench

Write-side companion to the 3-port register file: collects writeback results from the ALU and load paths and buffers them in a small FIFO. Drains one write per cycle onto the register file write port (RW, PW, LE). Drops writes to r0. Reports, combinationally, whether a register being read on RA/RB/RC still has a pending write, so issue logic can stall on read-after-write hazards.

---
 rtl/reg_file_write_queue.sv | 132 +++++++++++++
 tb/tb_reg_file_write_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_write_queue.sv
// Writeback queue: merges ALU and load results into a DEPTH-entry FIFO drained onto RW/PW/LE.
// Latency: a request accepted at edge N into an empty queue drives LE after edge N+1; one write per cycle.
// Backpressure: stall when fewer than two free slots; excess requests are dropped (load first) and flagged.
module reg_file_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_rd,
    input  logic [DW-1:0]            ld_data,
    input  logic [AW-1:0]            RA,
    input  logic [AW-1:0]            RB,
    input  logic [AW-1:0]            RC,
    output logic [AW-1:0]            RW,
    output logic [DW-1:0]            PW,
    output logic                     LE,
    output logic                     stall,
    output logic                     hazA,
    output logic                     hazB,
    output logic                     hazC,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]    mem_rd_q  [DEPTH];
    logic [DW-1:0]    mem_dat_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    rw_q;
    logic [DW-1:0]    pw_q;
    logic             le_q;

    logic             pop;
    logic             alu_req, ld_req;
    logic             alu_acc, ld_acc;
    logic [CW-1:0]    free_slots;
    logic [CW-1:0]    n_acc;
    logic [PTR_W-1:0] ld_slot;

    assign pop     = (count_q != '0);
    assign alu_req = alu_valid && (alu_rd != '0);
    assign ld_req  = ld_valid && (ld_rd != '0);

    // The head leaving this edge frees its slot for an incoming entry.
    assign free_slots = DEPTH_C - count_q + CW'(pop);
    assign alu_acc    = alu_req && (free_slots != '0);
    assign ld_acc     = ld_req && (free_slots >= (alu_acc ? CW'(2) : CW'(1)));
    assign n_acc      = CW'(alu_acc) + CW'(ld_acc);
    assign ld_slot    = alu_acc ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;

    assign count_d  = count_q - CW'(pop) + n_acc;
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(n_acc);
    assign ovf_d    = ovf_q | (alu_req & ~alu_acc) | (ld_req & ~ld_acc);

    always_ff @(posedge clk) begin
        if (alu_acc) begin
            mem_rd_q[wr_ptr_q]  <= alu_rd;
            mem_dat_q[wr_ptr_q] <= alu_data;
        end
        if (ld_acc) begin
            mem_rd_q[ld_slot]  <= ld_rd;
            mem_dat_q[ld_slot] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rw_q     <= '0;
            pw_q     <= '0;
            le_q     <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            le_q     <= pop;
            if (pop) begin
                rw_q <= mem_rd_q[rd_ptr_q];
                pw_q <= mem_dat_q[rd_ptr_q];
            end
        end
    end

    // An entry is live when its distance from the head is below the fill level.
    logic             hit_a, hit_b, hit_c;
    logic [PTR_W-1:0] offs;
    logic             ent_vld;

    always_comb begin
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        hit_c   = 1'b0;
        offs    = '0;
        ent_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offs    = PTR_W'(i) - rd_ptr_q;
            ent_vld = ({1'b0, offs} < count_q);
            if (ent_vld && (mem_rd_q[i] == RA)) hit_a = 1'b1;
            if (ent_vld && (mem_rd_q[i] == RB)) hit_b = 1'b1;
            if (ent_vld && (mem_rd_q[i] == RC)) hit_c = 1'b1;
        end
    end

    assign hazA = (RA != '0) && (hit_a || (le_q && (rw_q == RA)));
    assign hazB = (RB != '0) && (hit_b || (le_q && (rw_q == RB)));
    assign hazC = (RC != '0) && (hit_c || (le_q && (rw_q == RC)));

    assign stall    = (count_q >= DEPTH_C - CW'(1));
    assign count    = count_q;
    assign overflow = ovf_q;
    assign RW       = rw_q;
    assign PW       = pw_q;
    assign LE       = le_q;

endmodule

// File: tb/tb_reg_file_write_queue.sv
// Directed bench for reg_file_write_queue; a scoreboard of expected writes checks every LE cycle.
module tb_reg_file_write_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic [4:0]  RA = '0, RB = '0, RC = '0;
    logic [4:0]  RW;
    logic [31:0] PW;
    logic        LE, stall, hazA, hazB, hazC, overflow;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    logic [4:0]  exp_rd [$];
    logic [31:0] exp_pw [$];

    reg_file_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .RA(RA), .RB(RB), .RC(RC),
        .RW(RW), .PW(PW), .LE(LE), .stall(stall),
        .hazA(hazA), .hazB(hazB), .hazC(hazC),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then compare any issued write against the scoreboard head.
    task automatic step();
        @(posedge clk);
        #2;
        if (LE) begin
            if (exp_rd.size() == 0) begin
                chk("spurious_le", 64'(LE), 64'd0);
            end else begin
                chk("sb_rw", 64'(RW), 64'(exp_rd[0]));
                chk("sb_pw", 64'(PW), 64'(exp_pw[0]));
                void'(exp_rd.pop_front());
                void'(exp_pw.pop_front());
            end
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        exp_rd.push_back(r);
        exp_pw.push_back(d);
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while (exp_rd.size() != 0 && cyc < 50) begin
            step();
            cyc++;
        end
        chk({tag, "_drained"}, 64'(exp_rd.size()), 64'd0);
        step();
        chk({tag, "_count0"}, 64'(count), 64'd0);
    endtask

    initial begin
        int pairs;
        int cyc;
        logic stall_seen;
        logic [2:0] max_cnt;

        // Reset state
        #12;
        chk("rst_le", 64'(LE), 64'd0);
        chk("rst_rw", 64'(RW), 64'd0);
        chk("rst_pw", 64'(PW), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        #1 rst_n = 1'b1;
        step();

        // Single ALU write: LE one edge after acceptance, one cycle only
        drive(1'b1, 5'd5, 32'd20, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd5, 32'd20);
        step();
        idle();
        chk("t1_count1", 64'(count), 64'd1);
        chk("t1_le0", 64'(LE), 64'd0);
        step();
        chk("t1_le", 64'(LE), 64'd1);
        chk("t1_rw", 64'(RW), 64'd5);
        chk("t1_pw", 64'(PW), 64'd20);
        chk("t1_count0", 64'(count), 64'd0);
        step();
        chk("t1_le_off", 64'(LE), 64'd0);
        chk("t1_rw_hold", 64'(RW), 64'd5);

        // Dual request: ALU entry issues first
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
        expect_wr(5'd3, 32'hA);
        expect_wr(5'd4, 32'hB);
        step();
        idle();
        chk("t2_count2", 64'(count), 64'd2);
        step();
        chk("t2_rw_a", 64'(RW), 64'd3);
        chk("t2_pw_a", 64'(PW), 64'hA);
        chk("t2_count1", 64'(count), 64'd1);
        step();
        chk("t2_le_b", 64'(LE), 64'd1);
        chk("t2_rw_b", 64'(RW), 64'd4);
        chk("t2_pw_b", 64'(PW), 64'hB);
        step();
        chk("t2_le_off", 64'(LE), 64'd0);

        // Writes to r0 are discarded
        RA = 5'd0;
        drive(1'b1, 5'd0, 32'd99, 1'b0, 5'd0, 32'd0);
        step();
        idle();
        chk("t3_count", 64'(count), 64'd0);
        chk("t3_haza", 64'(hazA), 64'd0);
        step();
        chk("t3_le", 64'(LE), 64'd0);

        // Hazard held from enqueue through the LE cycle
        RA = 5'd7; RB = 5'd31; RC = 5'd0;
        #1;
        chk("t4_haza_pre", 64'(hazA), 64'd0);
        drive(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd7, 32'd1);
        step();
        idle();
        chk("t4_haza_q", 64'(hazA), 64'd1);
        chk("t4_hazb_q", 64'(hazB), 64'd0);
        step();
        chk("t4_le", 64'(LE), 64'd1);
        chk("t4_haza_le", 64'(hazA), 64'd1);
        chk("t4_hazb_le", 64'(hazB), 64'd0);
        step();
        chk("t4_haza_done", 64'(hazA), 64'd0);
        chk("t4_hazb_done", 64'(hazB), 64'd0);
        RA = 5'd0; RB = 5'd0;

        // Dual requests every cycle while honouring stall
        pairs = 0; cyc = 0; stall_seen = 1'b0; max_cnt = '0;
        while (pairs < 6 && cyc < 40) begin
            if (!stall) begin
                drive(1'b1, 5'(8 + 2 * pairs), 32'(100 + 2 * pairs),
                      1'b1, 5'(9 + 2 * pairs), 32'(101 + 2 * pairs));
                expect_wr(5'(8 + 2 * pairs), 32'(100 + 2 * pairs));
                expect_wr(5'(9 + 2 * pairs), 32'(101 + 2 * pairs));
                pairs++;
            end else begin
                idle();
            end
            step();
            cyc++;
            chk("t5_stall_vs_count", 64'(stall), 64'(count >= 3'd3));
            if (stall) stall_seen = 1'b1;
            if (count > max_cnt) max_cnt = count;
        end
        idle();
        chk("t5_pairs", 64'(pairs), 64'd6);
        chk("t5_stall_seen", 64'(stall_seen), 64'd1);
        chk("t5_max_count", 64'(max_cnt), 64'd3);
        drain("t5");
        chk("t5_ovf", 64'(overflow), 64'd0);

        // Ignore stall: fourth pair loses its load entry
        drive(1'b1, 5'd20, 32'd200, 1'b1, 5'd21, 32'd201);
        expect_wr(5'd20, 32'd200); expect_wr(5'd21, 32'd201);
        step();
        drive(1'b1, 5'd22, 32'd202, 1'b1, 5'd23, 32'd203);
        expect_wr(5'd22, 32'd202); expect_wr(5'd23, 32'd203);
        step();
        chk("t6_count3", 64'(count), 64'd3);
        drive(1'b1, 5'd24, 32'd204, 1'b1, 5'd25, 32'd205);
        expect_wr(5'd24, 32'd204); expect_wr(5'd25, 32'd205);
        step();
        chk("t6_count4", 64'(count), 64'd4);
        chk("t6_ovf_before", 64'(overflow), 64'd0);
        drive(1'b1, 5'd26, 32'd206, 1'b1, 5'd27, 32'd207);
        expect_wr(5'd26, 32'd206);
        step();
        idle();
        chk("t6_ovf_set", 64'(overflow), 64'd1);
        chk("t6_count_full", 64'(count), 64'd4);
        drain("t6");
        chk("t6_ovf_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset mid-drain
        drive(1'b1, 5'd30, 32'd300, 1'b1, 5'd31, 32'd301);
        expect_wr(5'd30, 32'd300); expect_wr(5'd31, 32'd301);
        step();
        drive(1'b1, 5'd12, 32'd302, 1'b1, 5'd13, 32'd303);
        expect_wr(5'd12, 32'd302); expect_wr(5'd13, 32'd303);
        step();
        idle();
        chk("t7_count3", 64'(count), 64'd3);
        chk("t7_le_pre", 64'(LE), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_le_rst", 64'(LE), 64'd0);
        chk("t7_count_rst", 64'(count), 64'd0);
        chk("t7_rw_rst", 64'(RW), 64'd0);
        chk("t7_pw_rst", 64'(PW), 64'd0);
        chk("t7_ovf_rst", 64'(overflow), 64'd0);
        exp_rd.delete();
        exp_pw.delete();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("t7_count_after", 64'(count), 64'd0);
        chk("t7_le_after", 64'(LE), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
